// File: rtl/lsu_pkg.sv
// Shared LSU definitions: ROB id width, the request payload carried to the AGU,
// and the default starvation limit for issue arbitration.
package lsu_pkg;
  localparam int ROB_W            = 6;
  localparam int STARVE_LIMIT_DEF = 7;

  typedef struct packed {
    logic [ROB_W-1:0] rob;
    logic [3:0]       op;
    logic [31:0]      data;
    logic [31:0]      addr;
    logic [5:0]       dest;
  } lsu_req_t;
endpackage

// File: rtl/rob_age_cmp.sv
// Wrap-around ROB age comparison: a_older_o is set when rob_a_i is strictly
// closer to the ROB head than rob_b_i (ages taken modulo the ROB size).
module rob_age_cmp
  import lsu_pkg::*;
(
  input  logic [ROB_W-1:0] rob_a_i,
  input  logic [ROB_W-1:0] rob_b_i,
  input  logic [ROB_W-1:0] head_i,
  output logic             a_older_o
);
  logic [ROB_W-1:0] age_a;
  logic [ROB_W-1:0] age_b;

  assign age_a     = rob_a_i - head_i;
  assign age_b     = rob_b_i - head_i;
  assign a_older_o = age_a < age_b;
endmodule

// File: rtl/agu_issue_arbiter.sv
// Two-port age-ordered issue arbiter in front of the AGU with a single
// registered output slot and per-port starvation override.
module agu_issue_arbiter
  import lsu_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  cpu_clock_i,
  input  logic                  cpu_reset_i,
  input  logic                  flush_i,
  input  logic [ROB_W-1:0]      rob_head_i,
  input  logic [1:0]            req_vld_i,
  output logic [1:0]            req_busy_o,
  input  logic [1:0][ROB_W-1:0] req_rob_i,
  input  logic [1:0][3:0]       req_op_i,
  input  logic [1:0][31:0]      req_data_i,
  input  logic [1:0][31:0]      req_addr_i,
  input  logic [1:0][5:0]       req_dest_i,
  output logic                  agu_vld_o,
  output logic [ROB_W-1:0]      agu_rob_o,
  output logic [3:0]            agu_op_o,
  output logic [31:0]           agu_data_o,
  output logic [31:0]           agu_addr_o,
  output logic [5:0]            agu_dest_o,
  input  logic                  agu_busy_i
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  lsu_req_t   req_pkt [2];
  lsu_req_t   slot_q, slot_d;
  logic       vld_q, vld_d;
  logic [3:0] cnt_q [2];
  logic [3:0] cnt_d [2];
  logic [1:0] grant;
  logic [1:0] starved;
  logic       port1_older;
  logic       slot_free;
  logic       arb_en;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pkt
      assign req_pkt[gi] = '{rob:  req_rob_i[gi],
                             op:   req_op_i[gi],
                             data: req_data_i[gi],
                             addr: req_addr_i[gi],
                             dest: req_dest_i[gi]};
      assign starved[gi] = req_vld_i[gi] && (cnt_q[gi] == LIMIT);
    end
  endgenerate

  // Strictly-older test on port 1 so an age tie falls through to port 0.
  rob_age_cmp u_age_cmp (
    .rob_a_i   (req_rob_i[1]),
    .rob_b_i   (req_rob_i[0]),
    .head_i    (rob_head_i),
    .a_older_o (port1_older)
  );

  assign slot_free = !vld_q || !agu_busy_i;
  assign arb_en    = slot_free && !flush_i && !cpu_reset_i;

  always_comb begin
    grant = 2'b00;
    if (arb_en) begin
      if (starved[0])              grant = 2'b01;
      else if (starved[1])         grant = 2'b10;
      else if (req_vld_i == 2'b11) grant = port1_older ? 2'b10 : 2'b01;
      else                         grant = req_vld_i;
    end
  end

  assign req_busy_o = ~grant;

  always_comb begin
    vld_d  = vld_q;
    slot_d = slot_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (grant != 2'b00) begin
      vld_d  = 1'b1;
      slot_d = grant[1] ? req_pkt[1] : req_pkt[0];
    end else if (vld_q && !agu_busy_i) begin
      vld_d = 1'b0;
    end
  end

  // Counters only advance on cycles where an arbitration actually took place.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush_i || !req_vld_i[i] || grant[i]) begin
        cnt_d[i] = 4'd0;
      end else if (slot_free && cnt_q[i] < LIMIT) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      vld_q    <= 1'b0;
      slot_q   <= '0;
      cnt_q[0] <= 4'd0;
      cnt_q[1] <= 4'd0;
    end else begin
      vld_q    <= vld_d;
      slot_q   <= slot_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign agu_vld_o  = vld_q;
  assign agu_rob_o  = slot_q.rob;
  assign agu_op_o   = slot_q.op;
  assign agu_data_o = slot_q.data;
  assign agu_addr_o = slot_q.addr;
  assign agu_dest_o = slot_q.dest;
endmodule

// File: doc/agu_issue_arbiter.md
AGU_ISSUE_ARBITER -- requirements
Module: agu_issue_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 7, meaning consecutive lost arbitrations before a port is force-granted (range 1-15).
REQ-002 SHALL have port cpu_clock_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port cpu_reset_i, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port flush_i, input, 1, pipeline flush that kills all in-flight state.
REQ-005 SHALL have port rob_head_i, input, 6, ROB id of the oldest uncommitted instruction.
REQ-006 SHALL have port req_vld_i, input, [1:0], per-requester valid; port 0 = memory IQ A, port 1 = memory IQ B.
REQ-007 SHALL have port req_busy_o, input-facing output, [1:0], per-requester stall; combinational; a request transfers when req_vld_i[n] && !req_busy_o[n].
REQ-008 SHALL have port req_rob_i, input, [1:0][5:0], ROB id per requester.
REQ-009 SHALL have port req_op_i, input, [1:0][3:0], LSU op; bit 3 = store.
REQ-010 SHALL have port req_data_i, input, [1:0][31:0], store data.
REQ-011 SHALL have port req_addr_i, input, [1:0][31:0], effective address.
REQ-012 SHALL have port req_dest_i, input, [1:0][5:0], load destination register.
REQ-013 SHALL have outputs agu_vld_o (1), agu_rob_o (6), agu_op_o (4), agu_data_o (32), agu_addr_o (32), agu_dest_o (6): the registered request presented to the AGU.
REQ-014 SHALL have port agu_busy_i, input, 1, AGU backpressure; the output transfers when agu_vld_o && !agu_busy_i.

Function
REQ-015 SHALL hold one output slot; the slot is free when !agu_vld_o or the output transfers in the same cycle.
REQ-016 SHALL grant at most one requester per cycle, and only when the slot is free and neither flush_i nor cpu_reset_i is asserted.
REQ-017 SHALL drive req_busy_o[n] = ~grant[n], so a non-valid port also reads busy unless granted.
REQ-018 SHALL, when only one port is valid, grant that port.
REQ-019 SHALL, when both ports are valid, compute age[n] = (req_rob_i[n] - rob_head_i) mod 64 and grant the smaller age.
REQ-020 SHALL break an age tie in favour of port 0.
REQ-021 SHALL let a starvation override take priority over the age rule in REQ-019.
REQ-022 SHALL keep a 4-bit starve counter per port: increment, saturating at STARVE_LIMIT, when the port is valid and not granted in a cycle where the slot is free.
REQ-023 SHALL clear a starve counter when its port is granted or its port is not valid.
REQ-024 SHALL force-grant port n when its starve counter equals STARVE_LIMIT; if both counters are at the limit, port 0 wins.
REQ-025 SHALL load the granted fields into the output slot on the grant cycle and set agu_vld_o the next cycle (latency 1).
REQ-026 SHALL keep agu_vld_o set and all payload outputs stable while agu_busy_i is high.
REQ-027 SHALL clear agu_vld_o and both starve counters on flush_i in the same edge, with no grant during flush.
REQ-028 SHALL, on a transfer with no new grant, clear agu_vld_o on the next edge.
REQ-029 SHALL support back-to-back transfers at one request per cycle while agu_busy_i is low.

Reset
REQ-030 SHALL on cpu_reset_i clear agu_vld_o, all payload outputs, and both starve counters to 0.
REQ-031 SHALL hold req_busy_o = 2'b11 while cpu_reset_i is high.
REQ-032 SHALL let reset take precedence over flush_i and agu_busy_i when asserted together or mid-stall.

Structure
REQ-033 SHALL place the following in shared package lsu_pkg: ROB_W=6, the lsu_req_t struct {rob, op, data, addr, dest} (80 bits), and the STARVE_LIMIT default.
REQ-034 SHALL implement the wrap-around age compare as sub-module rob_age_cmp (inputs: two ROB ids and head; output: a_older).

Verification
REQ-035 SHALL cover: head=0, port0 rob=5, port1 rob=3, both valid, slot empty -> port1 granted, agu_rob_o=3 next cycle, req_busy_o=2'b01.
REQ-036 SHALL cover: head=60, port0 rob=2, port1 rob=62 -> port1 granted (age 2 vs 6).
REQ-037 SHALL cover: port1 held valid while port0 presents 7 consecutive older requests -> port1 force-granted on the 8th arbitration cycle.
REQ-038 SHALL cover: agu_busy_i high for 5 cycles with agu_vld_o=1 -> payload unchanged, req_busy_o=2'b11 throughout, new grant in the cycle busy drops.
REQ-039 SHALL cover: flush_i asserted while agu_vld_o=1, agu_busy_i=1 and both ports valid -> agu_vld_o=0 next cycle, no grant, starve counters 0.
REQ-040 SHALL cover: cpu_reset_i asserted mid-stream -> all outputs 0 next edge, and normal arbitration resumes the cycle after deassertion.
